// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard bus: groups the ID-stage request signals and the pipeline
// control/status outputs of hazard_scoreboard.
//   master : ID stage side (drives instruction info, receives control)
//   slave  : hazard_scoreboard side
// Signals:
//   valid_ID, flush_ID, readReg1_IFID, readReg2_IFID, useRs1_ID, useRs2_ID,
//   branch_ID, regWrite_ID, writeReg_ID, lat_ID          (master -> slave)
//   pcWrite, write_IFID, mux_IDEX, stall, busy_vec, stall_count (slave -> master)
interface hazard_scoreboard_if #(
   parameter int unsigned N      = 5,
   parameter int unsigned LAT_W  = 3,
   parameter int unsigned PERF_W = 32
) ();
   logic                valid_ID;
   logic                flush_ID;
   logic [N-1:0]        readReg1_IFID;
   logic [N-1:0]        readReg2_IFID;
   logic                useRs1_ID;
   logic                useRs2_ID;
   logic                branch_ID;
   logic                regWrite_ID;
   logic [N-1:0]        writeReg_ID;
   logic [LAT_W-1:0]    lat_ID;

   logic                pcWrite;
   logic                write_IFID;
   logic                mux_IDEX;
   logic                stall;
   logic [2**N-1:0]     busy_vec;
   logic [PERF_W-1:0]   stall_count;

   modport master (
      output valid_ID, flush_ID, readReg1_IFID, readReg2_IFID, useRs1_ID, useRs2_ID,
             branch_ID, regWrite_ID, writeReg_ID, lat_ID,
      input  pcWrite, write_IFID, mux_IDEX, stall, busy_vec, stall_count
   );

   modport slave (
      input  valid_ID, flush_ID, readReg1_IFID, readReg2_IFID, useRs1_ID, useRs2_ID,
             branch_ID, regWrite_ID, writeReg_ID, lat_ID,
      output pcWrite, write_IFID, mux_IDEX, stall, busy_vec, stall_count
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Load-use / branch-operand hazard controller with a per-register countdown
// scoreboard of in-flight producers. Stall depth follows producer latency.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset
//   bus    : hazard_scoreboard_if slave (ID request in, PC/IF-ID/ID-EX control out,
//            busy vector and saturating stall-cycle counter out)
module hazard_scoreboard #(
   parameter int unsigned N      = 5,
   parameter int unsigned LAT_W  = 3,
   parameter int unsigned PERF_W = 32
) (
   input logic                clk,
   input logic                reset,
   hazard_scoreboard_if.slave bus
);
   localparam int unsigned NumRegs = 2 ** N;
   localparam int unsigned CntW    = LAT_W + 1;

   logic [CntW-1:0]   cnt_q [NumRegs];
   logic [CntW-1:0]   cnt_d [NumRegs];
   logic [PERF_W-1:0] stall_count_q, stall_count_d;

   logic [CntW-1:0]   cnt_rs1, cnt_rs2, new_cnt;
   logic              haz1, haz2, stall, issue;

   assign cnt_rs1 = cnt_q[bus.readReg1_IFID];
   assign cnt_rs2 = cnt_q[bus.readReg2_IFID];

   // Branches resolve in ID, one cycle before EX consumers, so they also
   // wait out the final countdown cycle that forwarding would cover.
   assign haz1 = bus.valid_ID & bus.useRs1_ID & (bus.readReg1_IFID != '0) &
                 (bus.branch_ID ? (cnt_rs1 != '0) : (cnt_rs1 > CntW'(1)));
   assign haz2 = bus.valid_ID & bus.useRs2_ID & (bus.readReg2_IFID != '0) &
                 (bus.branch_ID ? (cnt_rs2 != '0) : (cnt_rs2 > CntW'(1)));

   assign stall   = (haz1 | haz2) & ~bus.flush_ID;
   assign issue   = bus.valid_ID & ~stall & ~bus.flush_ID;
   assign new_cnt = CntW'(bus.lat_ID) + CntW'(1);

   always_comb begin
      for (int unsigned r = 0; r < NumRegs; r++) begin
         cnt_d[r] = (cnt_q[r] == '0) ? '0 : cnt_q[r] - CntW'(1);
         // WAW: keep the longer countdown so an older slow producer still blocks.
         if (issue && bus.regWrite_ID && (bus.writeReg_ID == N'(r)) && (new_cnt > cnt_d[r])) begin
            cnt_d[r] = new_cnt;
         end
      end
      cnt_d[0] = '0;
   end

   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + PERF_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned r = 0; r < NumRegs; r++) begin
            cnt_q[r] <= '0;
         end
         stall_count_q <= '0;
      end else begin
         cnt_q         <= cnt_d;
         stall_count_q <= stall_count_d;
      end
   end

   always_comb begin
      for (int unsigned r = 0; r < NumRegs; r++) begin
         bus.busy_vec[r] = (cnt_q[r] != '0);
      end
   end

   assign bus.stall       = stall;
   assign bus.pcWrite     = ~stall;
   assign bus.write_IFID  = ~stall;
   assign bus.mux_IDEX    = ~stall & ~bus.flush_ID;
   assign bus.stall_count = stall_count_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
   localparam int unsigned N      = 5;
   localparam int unsigned LAT_W  = 3;
   localparam int unsigned PERF_W = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   hazard_scoreboard_if #(.N(N), .LAT_W(LAT_W), .PERF_W(PERF_W)) bus ();

   hazard_scoreboard #(.N(N), .LAT_W(LAT_W), .PERF_W(PERF_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic        stall;
      logic        mux;
      int unsigned cnt;
      int unsigned reg_idx;
      logic        busy;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic drive(input logic v, input logic f, input int unsigned r1, input int unsigned r2,
                        input logic u1, input logic u2, input logic br, input logic rw,
                        input int unsigned rd, input int unsigned lat);
      bus.valid_ID      = v;
      bus.flush_ID      = f;
      bus.readReg1_IFID = r1[N-1:0];
      bus.readReg2_IFID = r2[N-1:0];
      bus.useRs1_ID     = u1;
      bus.useRs2_ID     = u2;
      bus.branch_ID     = br;
      bus.regWrite_ID   = rw;
      bus.writeReg_ID   = rd[N-1:0];
      bus.lat_ID        = lat[LAT_W-1:0];
   endtask

   task automatic push_exp(input string tag, input logic st, input logic mx, input int unsigned c,
                           input int unsigned ri, input logic b);
      exp_t e;
      e.tag = tag; e.stall = st; e.mux = mx; e.cnt = c; e.reg_idx = ri; e.busy = b;
      exp_q.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty: observed 0 entries expected at least 1");
         return;
      end
      e = exp_q.pop_front();
      checks++;
      assert (bus.stall === e.stall) else begin
         errors++;
         $error("FAIL %s stall: observed %b expected %b", e.tag, bus.stall, e.stall);
      end
      checks++;
      assert (bus.pcWrite === ~e.stall) else begin
         errors++;
         $error("FAIL %s pcWrite: observed %b expected %b", e.tag, bus.pcWrite, ~e.stall);
      end
      checks++;
      assert (bus.write_IFID === ~e.stall) else begin
         errors++;
         $error("FAIL %s write_IFID: observed %b expected %b", e.tag, bus.write_IFID, ~e.stall);
      end
      checks++;
      assert (bus.mux_IDEX === e.mux) else begin
         errors++;
         $error("FAIL %s mux_IDEX: observed %b expected %b", e.tag, bus.mux_IDEX, e.mux);
      end
      checks++;
      assert (bus.stall_count === PERF_W'(e.cnt)) else begin
         errors++;
         $error("FAIL %s stall_count: observed %0d expected %0d", e.tag, bus.stall_count, e.cnt);
      end
      checks++;
      assert (bus.busy_vec[e.reg_idx] === e.busy) else begin
         errors++;
         $error("FAIL %s busy_vec[%0d]: observed %b expected %b", e.tag, e.reg_idx,
                bus.busy_vec[e.reg_idx], e.busy);
      end
   endtask

   // Push expectation, sample mid-cycle, then advance to just after the next edge.
   task automatic run(input string tag, input logic st, input logic mx, input int unsigned c,
                      input int unsigned ri, input logic b);
      push_exp(tag, st, mx, c, ri, b);
      #2;
      check_out();
      @(posedge clk);
      #1;
   endtask

   int unsigned exp_cnt;

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      run("reset", 0, 1, 0, 5, 0);
      reset = 1'b0;

      // T1 ALU -> ALU
      drive(1, 0, 0, 0, 0, 0, 0, 1, 5, 0);  run("t1_add_x5", 0, 1, 0, 5, 0);
      drive(1, 0, 5, 0, 1, 0, 0, 0, 0, 0);  run("t1_use_x5", 0, 1, 0, 5, 1);

      // T2 load-use
      drive(1, 0, 0, 0, 0, 0, 0, 1, 5, 1);  run("t2_lw_x5", 0, 1, 0, 5, 0);
      drive(1, 0, 0, 5, 0, 1, 0, 0, 0, 0);  run("t2_use_stall", 1, 0, 0, 5, 1);
      run("t2_use_issue", 0, 1, 1, 5, 1);

      // T3 branch after load, then after ALU
      drive(1, 0, 0, 0, 0, 0, 0, 1, 6, 1);  run("t3_lw_x6", 0, 1, 1, 6, 0);
      drive(1, 0, 6, 0, 1, 0, 1, 0, 0, 0);  run("t3_beq_st1", 1, 0, 1, 6, 1);
      run("t3_beq_st2", 1, 0, 2, 6, 1);
      run("t3_beq_go", 0, 1, 3, 6, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 1, 6, 0);  run("t3_add_x6", 0, 1, 3, 6, 0);
      drive(1, 0, 6, 0, 1, 0, 1, 0, 0, 0);  run("t3_beq_alu_st", 1, 0, 3, 6, 1);
      run("t3_beq_alu_go", 0, 1, 4, 6, 0);

      // T4 multicycle producer then younger fast WAW
      drive(1, 0, 0, 0, 0, 0, 0, 1, 7, 6);  run("t4_div_x7", 0, 1, 4, 7, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 1, 7, 0);  run("t4_add_x7", 0, 1, 4, 7, 1);
      drive(1, 0, 7, 0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) run("t4_use_stall", 1, 0, 4 + i, 7, 1);
      run("t4_use_go", 0, 1, 9, 7, 1);

      // T5 flush overrides stall and blocks scoreboard update
      drive(1, 0, 0, 0, 0, 0, 0, 1, 8, 1);  run("t5_lw_x8", 0, 1, 9, 8, 0);
      drive(1, 1, 8, 0, 1, 0, 0, 1, 9, 3);  run("t5_flush", 0, 0, 9, 8, 1);
      drive(1, 0, 9, 0, 1, 0, 1, 0, 0, 0);  run("t5_no_upd_flush", 0, 1, 9, 9, 0);
      // stalled instruction must not write its rd
      drive(1, 0, 0, 0, 0, 0, 0, 1, 10, 1); run("t5_lw_x10", 0, 1, 9, 10, 0);
      drive(1, 0, 10, 0, 1, 0, 0, 1, 11, 5); run("t5_stall_wr", 1, 0, 9, 11, 0);
      drive(1, 0, 11, 0, 1, 0, 1, 0, 0, 0); run("t5_no_upd_stall", 0, 1, 10, 11, 0);
      // x0 never tracked
      drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 7);  run("t5_wr_x0", 0, 1, 10, 0, 0);
      drive(1, 0, 0, 0, 1, 1, 1, 0, 0, 0);  run("t5_rd_x0", 0, 1, 10, 0, 0);

      // T6 reset in the middle of a load-use stall
      drive(1, 0, 0, 0, 0, 0, 0, 1, 5, 1);  run("t6_lw_x5", 0, 1, 10, 5, 0);
      drive(1, 0, 5, 0, 1, 0, 0, 0, 0, 0);
      push_exp("t6_pre_reset", 1, 0, 10, 5, 1);
      #2;
      check_out();
      reset = 1'b1;
      #1;
      push_exp("t6_async_reset", 0, 1, 0, 5, 0);
      check_out();
      @(posedge clk);
      #1;
      reset = 1'b0;
      run("t6_after_reset", 0, 1, 0, 5, 0);

      // Saturation: 3 rounds of 8 stall cycles push the 4-bit counter past 15
      exp_cnt = 0;
      for (int k = 0; k < 3; k++) begin
         drive(1, 0, 0, 0, 0, 0, 0, 1, 13, 7); run("sat_issue", 0, 1, exp_cnt, 13, 0);
         drive(1, 0, 13, 0, 1, 0, 1, 0, 0, 0);
         for (int j = 0; j < 8; j++) begin
            run("sat_stall", 1, 0, exp_cnt, 13, 1);
            if (exp_cnt < 15) exp_cnt++;
         end
         run("sat_go", 0, 1, exp_cnt, 13, 0);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      run("sat_final", 0, 1, 15, 13, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
